// File: rtl/ifetch_if.sv
// Fetch-unit bundle: instruction-memory read port, decode handshake,
// execute redirect and misalign flag.
interface ifetch_if;
  logic [7:0]  adr;
  logic [31:0] Din;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        misalign;

  modport master (
    output adr,
    input  Din,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    input  redirect_valid,
    input  redirect_pc,
    output misalign
  );

  modport slave (
    input  adr,
    output Din,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    output redirect_valid,
    output redirect_pc,
    input  misalign
  );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch: PC owner, 1-cycle ROM latency absorber, skid-buffered output.
// Define IFETCH_MISALIGN_TRAP_EN to halt on misaligned redirect targets.
module ifetch #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic     clock,
  input  logic     reset,
  ifetch_if.master bus
);

  typedef enum logic [1:0] {RUN, HOLD, FLUSH, HALT} state_e;

  state_e      state_q, state_d;
  logic [7:0]  fetch_pc_q, fetch_pc_d;
  logic        inf_v_q, inf_v_d;
  logic [7:0]  inf_pc_q, inf_pc_d;
  logic        out_v_q, out_v_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [7:0]  out_pc_q, out_pc_d;
  logic        skid_v_q, skid_v_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [7:0]  skid_pc_q, skid_pc_d;
  logic        mis_q, mis_d;

  logic out_free;
  logic stall_inf;
  logic can_issue;

  assign out_free  = ~out_v_q | bus.out_ready;
  assign stall_inf = out_v_q & ~bus.out_ready & inf_v_q;

  // HOLD may issue on the edge the skid drains, keeping the resume bubble-free
  always_comb begin
    can_issue = 1'b0;
    unique case (state_q)
      RUN:   can_issue = ~skid_v_q & ~stall_inf;
      HOLD:  can_issue = out_free & ~stall_inf;
      FLUSH: can_issue = 1'b1;
      HALT:  can_issue = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    inf_v_d      = inf_v_q;
    inf_pc_d     = inf_pc_q;
    out_v_d      = out_v_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_v_d     = skid_v_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    mis_d        = mis_q;

    if (out_free) begin
      if (skid_v_q) begin
        out_v_d      = 1'b1;
        out_instr_d  = skid_instr_q;
        out_pc_d     = skid_pc_q;
        skid_v_d     = inf_v_q;
        skid_instr_d = bus.Din;
        skid_pc_d    = inf_pc_q;
      end else if (inf_v_q) begin
        out_v_d     = 1'b1;
        out_instr_d = bus.Din;
        out_pc_d    = inf_pc_q;
      end else begin
        out_v_d = 1'b0;
      end
    end else if (inf_v_q) begin
      skid_v_d     = 1'b1;
      skid_instr_d = bus.Din;
      skid_pc_d    = inf_pc_q;
    end

    if (can_issue) begin
      inf_v_d    = 1'b1;
      inf_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 8'd4;
    end else begin
      inf_v_d = 1'b0;
    end

    if (skid_v_d)
      state_d = HOLD;
    else if (state_q == HALT)
      state_d = HALT;
    else
      state_d = RUN;

    if (bus.redirect_valid) begin
      out_v_d    = 1'b0;
      skid_v_d   = 1'b0;
      inf_v_d    = 1'b0;
      fetch_pc_d = {bus.redirect_pc[7:2], 2'b00};
      state_d    = FLUSH;
      mis_d      = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      if (bus.redirect_pc[1:0] != 2'b00) begin
        mis_d   = 1'b1;
        state_d = HALT;
      end
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      fetch_pc_q   <= RESET_PC;
      inf_v_q      <= 1'b0;
      inf_pc_q     <= 8'h00;
      out_v_q      <= 1'b0;
      out_instr_q  <= 32'h0;
      out_pc_q     <= 8'h00;
      skid_v_q     <= 1'b0;
      skid_instr_q <= 32'h0;
      skid_pc_q    <= 8'h00;
      mis_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      inf_v_q      <= inf_v_d;
      inf_pc_q     <= inf_pc_d;
      out_v_q      <= out_v_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_v_q     <= skid_v_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      mis_q        <= mis_d;
    end
  end

  assign bus.adr       = fetch_pc_q;
  assign bus.out_valid = out_v_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_pc    = out_pc_q;

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign bus.misalign = mis_q;
`else
  logic unused_mis;
  logic unused_lsb;
  assign unused_mis   = mis_q;
  assign unused_lsb   = ^bus.redirect_pc[1:0];
  assign bus.misalign = 1'b0;
`endif

endmodule
